// File: rtl/pad_bus_pkg.sv
// Shared types and default constants for the pad bus controller.
// Holds the FSM state enum, default parameter values and the phase-counter helper.
package pad_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        TURN   = 2'd3
    } pb_state_e;

    localparam int unsigned PB_W_DEF          = 8;
    localparam int unsigned PB_DRIVE_CYC_DEF  = 2;
    localparam int unsigned PB_TURN_CYC_DEF   = 1;
    localparam int unsigned PB_SETTLE_CYC_DEF = 2;
    localparam int unsigned PB_CNT_W          = 4;

    typedef logic [PB_CNT_W-1:0] pb_cnt_t;

    // A phase of n cycles loads n-1 so the phase ends on the cycle the counter reads 0.
    function automatic pb_cnt_t cnt_load(input int unsigned n);
        return (n == 0) ? '0 : pb_cnt_t'(n - 1);
    endfunction

endpackage

// File: rtl/pad_bus_arb.sv
// Two-way round-robin arbiter between the write and read requesters.
// Grants only while enabled; the last-served pointer resets to favour the write side.
module pad_bus_arb (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_wr_req,
    input  logic i_rd_req,
    output logic o_wr_gnt,
    output logic o_rd_gnt
);

    logic r_last_rd;
    logic w_wr_gnt;
    logic w_rd_gnt;

    // On contention the side not served last wins; r_last_rd=1 hands the tie to write.
    assign w_wr_gnt = i_en & i_wr_req & (~i_rd_req | r_last_rd);
    assign w_rd_gnt = i_en & i_rd_req & ~w_wr_gnt;

    assign o_wr_gnt = w_wr_gnt;
    assign o_rd_gnt = w_rd_gnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_rd <= 1'b1;
        end else if (w_wr_gnt) begin
            r_last_rd <= 1'b0;
        end else if (w_rd_gnt) begin
            r_last_rd <= 1'b1;
        end
    end

endmodule

// File: rtl/pad_bus_ctrl.sv
// Bidirectional pad bank controller: arbitrates write/read requests, drives DO/OEN
// for writes, samples DI after a settle window for reads, and enforces bus turnaround.
module pad_bus_ctrl
    import pad_bus_pkg::*;
#(
    parameter int unsigned W          = PB_W_DEF,
    parameter int unsigned DRIVE_CYC  = PB_DRIVE_CYC_DEF,
    parameter int unsigned TURN_CYC   = PB_TURN_CYC_DEF,
    parameter int unsigned SETTLE_CYC = PB_SETTLE_CYC_DEF
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         wr_req,
    input  logic [W-1:0] wr_data,
    output logic         wr_gnt,
    output logic         wr_done,
    input  logic         rd_req,
    output logic         rd_gnt,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    output logic         busy,
    output logic [W-1:0] DO,
    output logic         OEN,
    input  logic [W-1:0] DI
);

    pb_state_e    r_state;
    pb_state_e    w_state_nxt;
    pb_cnt_t      r_cnt;
    pb_cnt_t      w_cnt_nxt;
    logic         r_oen;
    logic         w_oen_nxt;
    logic         r_wr_done;
    logic         w_wr_done_nxt;
    logic         r_rd_valid;
    logic         w_rd_cap;
    logic [W-1:0] r_do;
    logic [W-1:0] r_rd_data;
    logic         w_arb_en;
    logic         w_wr_gnt;
    logic         w_rd_gnt;

    // Grants are combinational, so gate them with reset to keep them low while held.
    assign w_arb_en = (r_state == IDLE) & RST_N;

    pad_bus_arb u_arb (
        .i_clk    (CLK),
        .i_rst_n  (RST_N),
        .i_en     (w_arb_en),
        .i_wr_req (wr_req),
        .i_rd_req (rd_req),
        .o_wr_gnt (w_wr_gnt),
        .o_rd_gnt (w_rd_gnt)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_oen_nxt     = 1'b0;
        w_wr_done_nxt = 1'b0;
        w_rd_cap      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_wr_gnt) begin
                    w_state_nxt = DRIVE;
                    w_cnt_nxt   = cnt_load(DRIVE_CYC);
                    w_oen_nxt   = 1'b1;
                end else if (w_rd_gnt) begin
                    w_state_nxt = SAMPLE;
                    w_cnt_nxt   = cnt_load(SETTLE_CYC);
                end
            end
            DRIVE: begin
                if (r_cnt == '0) begin
                    w_wr_done_nxt = 1'b1;
                    if (TURN_CYC == 0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = TURN;
                        w_cnt_nxt   = cnt_load(TURN_CYC);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    w_oen_nxt = 1'b1;
                end
            end
            SAMPLE: begin
                if (r_cnt == '0) begin
                    w_rd_cap = 1'b1;
                    if (TURN_CYC == 0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = TURN;
                        w_cnt_nxt   = cnt_load(TURN_CYC);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            TURN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // OEN is registered so it tracks DRIVE exactly and drops asynchronously on reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_oen      <= 1'b0;
            r_wr_done  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_do       <= '0;
            r_rd_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_oen      <= w_oen_nxt;
            r_wr_done  <= w_wr_done_nxt;
            r_rd_valid <= w_rd_cap;
            if (w_wr_gnt) begin
                r_do <= wr_data;
            end
            if (w_rd_cap) begin
                r_rd_data <= DI;
            end
        end
    end

    assign wr_gnt   = w_wr_gnt;
    assign rd_gnt   = w_rd_gnt;
    assign wr_done  = r_wr_done;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign DO       = r_do;
    assign OEN      = r_oen;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_pad_bus_ctrl.sv
// Scoreboard bench for pad_bus_ctrl: two instances (TURN_CYC=1 and TURN_CYC=0) share
// stimulus; a timeline model predicts grants, pulses and pad levels per cycle.
module tb_pad_bus_ctrl;

    localparam int D = 2;
    localparam int S = 2;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } ev_t;

    // Queue index = instance*4 + kind (0 wr_gnt, 1 wr_done, 2 rd_gnt, 3 rd_valid).
    ev_t evq[8][$];
    string kname[4] = '{"wr_gnt", "wr_done", "rd_gnt", "rd_valid"};

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       wr_req = 1'b0;
    logic       rd_req = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] DI = 8'h00;
    logic [1:0] wr_gnt, wr_done, rd_gnt, rd_valid, busy, OEN;
    logic [7:0] rd_data [2];
    logic [7:0] DO_o [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic mon_en = 1'b0;

    int         busy_from [2];
    int         busy_end  [2];
    int         oen_from  [2];
    int         oen_to    [2];
    int         do_at     [2];
    int         cap_cyc   [2];
    logic       cap_pend  [2];
    logic       last_rd   [2];
    logic [7:0] do_next   [2];
    logic [7:0] do_exp    [2];
    logic [7:0] rd_exp    [2];

    pad_bus_ctrl #(.W(8), .DRIVE_CYC(D), .TURN_CYC(1), .SETTLE_CYC(S)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N),
        .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wr_gnt[0]), .wr_done(wr_done[0]),
        .rd_req(rd_req), .rd_gnt(rd_gnt[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
        .busy(busy[0]), .DO(DO_o[0]), .OEN(OEN[0]), .DI(DI)
    );

    pad_bus_ctrl #(.W(8), .DRIVE_CYC(D), .TURN_CYC(0), .SETTLE_CYC(S)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N),
        .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wr_gnt[1]), .wr_done(wr_done[1]),
        .rd_req(rd_req), .rd_gnt(rd_gnt[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
        .busy(busy[1]), .DO(DO_o[1]), .OEN(OEN[1]), .DI(DI)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int turn_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    task automatic check(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, i, cyc, act, exp);
        end
    endtask

    task automatic push_ev(input int k, input int c, input logic [7:0] d);
        ev_t e;
        e.cyc  = c;
        e.data = d;
        evq[k].push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            busy_from[i] = 0;
            busy_end[i]  = -1;
            oen_from[i]  = 0;
            oen_to[i]    = -1;
            do_at[i]     = -1;
            cap_cyc[i]   = -1;
            cap_pend[i]  = 1'b0;
            last_rd[i]   = 1'b1;
            do_next[i]   = 8'h00;
            do_exp[i]    = 8'h00;
            rd_exp[i]    = 8'h00;
        end
        for (int k = 0; k < 8; k++) evq[k].delete();
    endtask

    // Drive one cycle of inputs and predict each instance's reaction to them.
    task automatic step(input logic wr, input logic rd, input logic [7:0] wd, input logic [7:0] di);
        int t;
        wr_req  = wr;
        rd_req  = rd;
        wr_data = wd;
        DI      = di;
        for (int i = 0; i < 2; i++) begin
            t = turn_of(i);
            if (cap_pend[i] && cap_cyc[i] == cyc) begin
                push_ev(i*4 + 3, cyc + 1, di);
                cap_pend[i] = 1'b0;
            end
            if (cyc > busy_end[i] && (wr || rd)) begin
                if (wr && (!rd || last_rd[i])) begin
                    push_ev(i*4 + 0, cyc, wd);
                    push_ev(i*4 + 1, cyc + D + 1, wd);
                    oen_from[i]  = cyc + 1;
                    oen_to[i]    = cyc + D;
                    do_at[i]     = cyc + 1;
                    do_next[i]   = wd;
                    busy_from[i] = cyc + 1;
                    busy_end[i]  = cyc + D + t;
                    last_rd[i]   = 1'b0;
                end else begin
                    push_ev(i*4 + 2, cyc, 8'h00);
                    cap_pend[i]  = 1'b1;
                    cap_cyc[i]   = cyc + S;
                    busy_from[i] = cyc + 1;
                    busy_end[i]  = cyc + S + t;
                    last_rd[i]   = 1'b1;
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int ncyc);
        RST_N  = 1'b0;
        wr_req = 1'b1;
        rd_req = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_oen", i, OEN[i], 1'b0);
            check("rst_busy", i, busy[i], 1'b0);
            check("rst_wr_gnt", i, wr_gnt[i], 1'b0);
            check("rst_rd_gnt", i, rd_gnt[i], 1'b0);
            check("rst_wr_done", i, wr_done[i], 1'b0);
            check("rst_rd_valid", i, rd_valid[i], 1'b0);
            check("rst_do", i, DO_o[i], 8'h00);
            check("rst_rd_data", i, rd_data[i], 8'h00);
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        model_reset();
        repeat (ncyc) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    task automatic mon_cycle();
        logic obs;
        logic ok;
        logic exp_now;
        ev_t  e;
        int   k;
        for (int i = 0; i < 2; i++) begin
            if (do_at[i] == cyc) do_exp[i] = do_next[i];
            check("oen", i, OEN[i], (cyc >= oen_from[i] && cyc <= oen_to[i]));
            check("busy", i, busy[i], (cyc >= busy_from[i] && cyc <= busy_end[i]));
            check("do", i, DO_o[i], do_exp[i]);
            for (int j = 0; j < 4; j++) begin
                k = i*4 + j;
                case (j)
                    0:       obs = wr_gnt[i];
                    1:       obs = wr_done[i];
                    2:       obs = rd_gnt[i];
                    default: obs = rd_valid[i];
                endcase
                exp_now = (evq[k].size() > 0) && (evq[k][0].cyc == cyc);
                e.cyc  = -1;
                e.data = 8'h00;
                if (exp_now) e = evq[k][0];
                if (obs || exp_now) begin
                    n_tests++;
                    ok = obs && exp_now;
                    if (ok && j == 1) ok = (DO_o[i] == e.data);
                    if (ok && j == 3) ok = (rd_data[i] == e.data);
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL ev_%s dut%0d cycle %0d: seen=%0b do=%h rd_data=%h required=%0b data=%h",
                                 kname[j], i, cyc, obs, DO_o[i], rd_data[i], exp_now, e.data);
                    end
                    if (exp_now) begin
                        if (j == 3) rd_exp[i] = e.data;
                        void'(evq[k].pop_front());
                    end
                end
            end
            check("rd_data", i, rd_data[i], rd_exp[i]);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en && RST_N === 1'b1) mon_cycle();
    end

    initial begin
        model_reset();
        @(posedge CLK);
        #1;
        do_reset(3);
        mon_en = 1'b1;
        repeat (2) step(1'b0, 1'b0, 8'h00, 8'h00);

        // Lone write of A5, then lone read with DI parked at 3C.
        step(1'b1, 1'b0, 8'hA5, 8'h00);
        repeat (5) step(1'b0, 1'b0, 8'h00, 8'h3C);
        step(1'b0, 1'b1, 8'h00, 8'h3C);
        repeat (5) step(1'b0, 1'b0, 8'h00, 8'h3C);

        // Contention from a fresh reset: write must win first, then alternate.
        do_reset(1);
        repeat (20) step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
        repeat (6) step(1'b0, 1'b0, 8'h00, 8'h00);

        // Reset during the first DRIVE cycle abandons the write.
        step(1'b1, 1'b0, 8'h5A, 8'h00);
        do_reset(2);
        repeat (6) step(1'b0, 1'b0, 8'h00, 8'h00);

        // Back-to-back writes 11 then 22.
        step(1'b1, 1'b0, 8'h11, 8'h00);
        repeat (4) step(1'b1, 1'b0, 8'h22, 8'h00);
        repeat (8) step(1'b0, 1'b0, 8'h00, 8'h00);

        // Read request pulsed for one cycle while busy is dropped.
        step(1'b1, 1'b0, 8'h77, 8'h00);
        step(1'b0, 1'b1, 8'h00, 8'h99);
        repeat (8) step(1'b0, 1'b0, 8'h00, 8'h99);

        // Random traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(1 + int'($urandom_range(0, 2)));
            end else begin
                step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 40,
                     8'($urandom), 8'($urandom));
            end
        end

        repeat (30) step(1'b0, 1'b0, 8'h00, 8'h00);
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (evq[k].size() != 0) begin
                n_fail++;
                $display("FAIL drain_%s dut%0d: %0d events outstanding, required 0",
                         kname[k % 4], k / 4, evq[k].size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pad_bus_ctrl.md
PAD_BUS_CTRL -- requirements
Module: pad_bus_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the pad bank width in bits.
REQ-002 The block SHALL have parameter DRIVE_CYC, default 2, giving the number of cycles OEN is held high per write; legal range 1..15.
REQ-003 The block SHALL have parameter TURN_CYC, default 1, giving the number of cycles the bus is released after each operation; legal range 0..15.
REQ-004 The block SHALL have parameter SETTLE_CYC, default 2, giving the number of cycles the bus is released before DI is captured on a read; legal range 1..15.
REQ-005 The block SHALL have the port: CLK  in  1  single rising-edge clock.
REQ-006 The block SHALL have the port: RST_N  in  1  asynchronous active-low reset.
REQ-007 The block SHALL have the port: wr_req  in  1  write request, held until granted.
REQ-008 The block SHALL have the port: wr_data  in  W  write word, sampled in the wr_gnt cycle.
REQ-009 The block SHALL have the port: wr_gnt  out  1  write accepted; combinational, high for one cycle.
REQ-010 The block SHALL have the port: wr_done  out  1  one-cycle pulse when the write drive phase ends.
REQ-011 The block SHALL have the port: rd_req  in  1  read request, held until granted.
REQ-012 The block SHALL have the port: rd_gnt  out  1  read accepted; combinational, high for one cycle.
REQ-013 The block SHALL have the port: rd_data  out  W  captured pad word.
REQ-014 The block SHALL have the port: rd_valid  out  1  one-cycle pulse qualifying rd_data.
REQ-015 The block SHALL have the port: busy  out  1  high in every state except IDLE.
REQ-016 The block SHALL have the port: DO  out  W  data to the pad cells.
REQ-017 The block SHALL have the port: OEN  out  1  pad drive enable, fanned to all W pads; 1 means the pads drive.
REQ-018 The block SHALL have the port: DI  in  W  data returned from the pad cells.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, DRIVE, SAMPLE and TURN.
REQ-020 Grants SHALL be issued only in IDLE, and at most one grant SHALL be issued per cycle.
REQ-021 When only one request is active in IDLE, that request SHALL be granted.
REQ-022 When both requests are active in IDLE, the grant SHALL go to the requester not served last (round-robin); after reset the write side SHALL have priority.
REQ-023 On a wr_gnt edge, DO SHALL load wr_data, OEN SHALL rise and the state SHALL become DRIVE.
REQ-024 OEN SHALL stay high for exactly DRIVE_CYC cycles.
REQ-025 DO SHALL be held stable while OEN is high and SHALL hold its value after the write.
REQ-026 On leaving DRIVE, OEN SHALL fall and wr_done SHALL pulse in the first cycle after DRIVE.
REQ-027 On an rd_gnt edge, the state SHALL become SAMPLE with OEN low.
REQ-028 After SETTLE_CYC SAMPLE cycles, DI SHALL be registered into rd_data.
REQ-029 rd_valid SHALL pulse in the cycle immediately after the last SAMPLE cycle.
REQ-030 rd_data SHALL hold its value until the next capture.
REQ-031 Every DRIVE or SAMPLE phase SHALL be followed by TURN_CYC cycles in TURN with OEN low before the FSM returns to IDLE.
REQ-032 When TURN_CYC is 0, TURN SHALL be skipped.
REQ-033 The minimum period between writes SHALL be DRIVE_CYC+TURN_CYC+1 cycles.
REQ-034 OEN SHALL never be high outside DRIVE.
REQ-035 A request deasserted before its grant SHALL produce no operation.
REQ-036 Requests arriving while busy SHALL be ignored until IDLE.
REQ-037 Phase counters SHALL be 4 bits wide and SHALL count down to 0 without wrap.

Reset
REQ-038 While RST_N is low, OEN SHALL be 0 asynchronously, including mid-DRIVE.
REQ-039 Reset SHALL force the state to IDLE; DO, rd_data and the counters to 0; wr_done, rd_valid, wr_gnt, rd_gnt and busy to 0; and the round-robin pointer to favour write.
REQ-040 An operation interrupted by reset SHALL be abandoned, with no done or valid pulse after reset is released.

Structure
REQ-041 A package pad_bus_pkg SHALL hold the state enum and the default parameter constants.
REQ-042 A sub-module pad_bus_arb SHALL implement the two-way round-robin arbiter, including its last-served pointer.

Verification
REQ-043 Write only: wr_req with wr_data=8'hA5 at cycle 0 -> wr_gnt in cycle 0, DO=A5 and OEN=1 in cycles 1-2, OEN=0 and wr_done=1 in cycle 3, IDLE in cycle 4.
REQ-044 Read only: DI=8'h3C, rd_req at cycle 0 -> OEN=0 throughout, rd_data=3C and rd_valid=1 in cycle 3.
REQ-045 Contention after reset: wr_req and rd_req held together -> grant order write, read, write, read, with OEN=0 for at least 1 cycle between every write and read.
REQ-046 Reset mid-write: RST_N low during cycle 1 of DRIVE -> OEN=0 immediately, no wr_done pulse, FSM in IDLE after release.
REQ-047 TURN_CYC=0, back-to-back writes 11 then 22 -> grants 3 cycles apart, OEN low for exactly 1 cycle between the writes.
REQ-048 Request withdrawal: rd_req pulsed for 1 cycle while busy -> no rd_gnt and no rd_valid.
